// File: rtl/stmt_check_pkg.sv
// Shared types and constants for the statement-check arbiter.
// Optional statistics counters are enabled with the STMT_CHECK_STATS_EN macro.
package stmt_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    WAIT,
    SAMPLE
  } state_t;

  // Source identifier: 0 = S0, 1 = S1.
  typedef logic src_t;

  localparam logic [7:0] CHAR_SEMI  = 8'h3B;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stmt_check_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// source that was not granted last.
module rr_arb2
  import stmt_check_pkg::*;
(
  input  logic [1:0] i_req,
  input  src_t       i_last,
  output logic       o_any,
  output src_t       o_pick
);

  always_comb begin
    o_any = |i_req;
    case (i_req)
      2'b01:   o_pick = 1'b0;
      2'b10:   o_pick = 1'b1;
      default: o_pick = ~i_last;
    endcase
  end

endmodule

// File: rtl/stmt_check_arbiter.sv
// Grants one of two char streams a whole ';'-terminated statement on a shared
// checker and returns a tagged verdict. STMT_CHECK_STATS_EN adds result counters.
module stmt_check_arbiter
  import stmt_check_pkg::*;
#(
  parameter int         TIMEOUT   = 16,
  parameter logic [7:0] IDLE_CHAR = CHAR_SPACE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_char,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_char,
  output logic       s1_ready,
  output logic       chk_reset,
  output logic [7:0] chk_in,
  input  logic       chk_out,
  output logic       res_valid,
  output logic       res_src,
  output logic       res_pass,
  output logic       res_timeout,
  output logic       busy,
  output logic [1:0] grant
`ifdef STMT_CHECK_STATS_EN
  ,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic [15:0] to_cnt
`endif
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t         r_state, w_state_nxt;
  src_t           r_owner, w_owner_nxt;
  src_t           r_last_grant, w_last_nxt;
  logic [TCW-1:0] r_tcnt, w_tcnt_nxt;
  logic           r_to_flag, w_to_nxt;
  logic           r_rst_d;
  logic [7:0]     w_chk_in_nxt;
  logic           w_arb_any;
  src_t           w_arb_pick;
  logic           w_own_valid;
  logic [7:0]     w_own_char;

  rr_arb2 u_arb (
    .i_req  ({s1_valid, s0_valid}),
    .i_last (r_last_grant),
    .o_any  (w_arb_any),
    .o_pick (w_arb_pick)
  );

  assign w_own_valid = r_owner ? s1_valid : s0_valid;
  assign w_own_char  = r_owner ? s1_char  : s0_char;
  assign busy        = (r_state != IDLE);
  assign grant       = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_tcnt       <= '0;
      r_to_flag    <= 1'b0;
      chk_in       <= IDLE_CHAR;
      chk_reset    <= 1'b1;
      r_rst_d      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_to_flag    <= w_to_nxt;
      chk_in       <= w_chk_in_nxt;
      // Hold the checker in reset one extra cycle past our own reset.
      chk_reset    <= r_rst_d;
      r_rst_d      <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last_grant;
    w_tcnt_nxt   = r_tcnt;
    w_to_nxt     = r_to_flag;
    w_chk_in_nxt = IDLE_CHAR;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    res_valid    = 1'b0;
    res_src      = 1'b0;
    res_pass     = 1'b0;
    res_timeout  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_owner_nxt = w_arb_pick;
          w_tcnt_nxt  = '0;
          w_state_nxt = FWD;
        end
      end
      FWD: begin
        s0_ready = (r_owner == 1'b0);
        s1_ready = (r_owner == 1'b1);
        if (w_own_valid) begin
          w_chk_in_nxt = w_own_char;
          w_tcnt_nxt   = '0;
          if (w_own_char == CHAR_SEMI) w_state_nxt = WAIT;
        end else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
          // Stalled too long: terminate the statement on the owner's behalf.
          w_chk_in_nxt = CHAR_SEMI;
          w_to_nxt     = 1'b1;
          w_tcnt_nxt   = '0;
          w_state_nxt  = WAIT;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      WAIT: begin
        w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        res_valid   = 1'b1;
        res_src     = r_owner;
        res_pass    = chk_out & ~r_to_flag;
        res_timeout = r_to_flag;
        w_last_nxt  = r_owner;
        w_to_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef STMT_CHECK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      to_cnt   <= '0;
    end else if (res_valid) begin
      if (res_pass) pass_cnt <= sat_inc16(pass_cnt);
      else          fail_cnt <= sat_inc16(fail_cnt);
      if (res_timeout) to_cnt <= sat_inc16(to_cnt);
    end
  end
`endif

endmodule

// File: doc/stmt_check_arbiter.md
Name: stmt_check_arbiter

Overview:
- Shares one single-char-per-cycle declaration checker between two statement sources (S0, S1).
- Grants one source for a whole `;`-terminated statement and forwards its chars into the checker.
- Captures the checker's verdict and returns a tagged result; a stalled statement is flushed by timeout.
- Sits between the char-stream producers and the shared recognizer.

Parameters:
TIMEOUT, 16, consecutive granted-source idle cycles in FWD before forced flush (>=1)
IDLE_CHAR, 8'h20, char driven to checker when no statement is in flight (space)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
s0_valid  in  1  S0 char valid
s0_char  in  8  S0 char
s0_ready  out  1  S0 char accepted this cycle when valid&ready
s1_valid  in  1  S1 char valid
s1_char  in  8  S1 char
s1_ready  out  1  S1 char accepted
chk_reset  out  1  checker reset (registered)
chk_in  out  8  char to checker (registered)
chk_out  in  1  checker verdict, valid in SAMPLE
res_valid  out  1  one-cycle result pulse
res_src  out  1  source of result (0/1)
res_pass  out  1  checker verdict (0 on timeout)
res_timeout  out  1  statement was force-flushed
busy  out  1  state != IDLE
grant  out  2  one-hot current owner, 00 in IDLE

Behaviour:
- Reset values: all outputs 0 except chk_in=IDLE_CHAR and chk_reset=1 for the reset cycle plus one cycle after. State=IDLE, last_grant=1 (S0 wins first tie), timeout counter=0.
- States: IDLE, FWD, WAIT, SAMPLE.
- IDLE: ready=0. If any valid, register owner and go to FWD. If both valid, owner is !last_grant (round-robin); single requester always wins. chk_in=IDLE_CHAR.
- FWD: owner_ready=1, other ready=0.
  - On handshake, chk_in<=char and tcnt<=0.
  - If that char is `;` (8'h3B), go to WAIT.
  - If owner valid=0, chk_in<=IDLE_CHAR and tcnt++. Idle spaces inside a statement are legal whitespace for the checker; the stall is tolerated.
  - When tcnt reaches TIMEOUT-1 with valid still 0: chk_in<=`;`, set to_flag, go to WAIT.
- WAIT: ready=0. Checker consumes `;` at the end of this cycle. chk_in<=IDLE_CHAR.
- SAMPLE: ready=0. res_valid=1, res_src=owner, res_pass=chk_out & !to_flag, res_timeout=to_flag. last_grant<=owner, clear to_flag, go to IDLE.
- Latency: `;` handshake at edge N → res_valid high during cycle N+2. Minimum statement period is char count + 3 cycles.
- Non-owner valid held during a statement: no accept, no drop; it is served next IDLE.
- Owner char after its `;`: not accepted until re-granted.
- Statements are never interleaved.
- reset mid-statement: abort, no res_valid, checker reset via chk_reset.
- Empty statement `;`: forwarded, checker reports fail, res_pass=0.

Optional Feature:
STMT_CHECK_STATS_EN:
- Defined: add outputs pass_cnt[15:0], fail_cnt[15:0], to_cnt[15:0].
  - Counters are saturating (stop at 16'hFFFF) and increment on res_valid.
  - pass_cnt counts res_pass=1; fail_cnt counts res_pass=0; to_cnt counts res_timeout=1.
  - All counters clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package stmt_check_pkg: state enum (IDLE/FWD/WAIT/SAMPLE), CHAR_SEMI=8'h3B, CHAR_SPACE=8'h20, source-id type.
- One sub-module, rr_arb2: 2-way round-robin pick from valid and last_grant. Everything else stays inline.

Test Plan:
- S0 streams "int a;" with S1 idle → chk_in sequence matches; res_valid in cycle N+2 after `;`; res_src=0, res_pass=1, res_timeout=0.
- S0 and S1 both valid from reset, S0 "int 1x;", S1 "int b,c;" → S0 served first with res_pass=0; then S1 with res_pass=1; no char interleaving; s1_ready=0 throughout S0's statement.
- Both sources hold valid for 4 back-to-back statements → grants alternate 0,1,0,1.
- S1 sends "int ab", then valid=0 for TIMEOUT=16 cycles → forced `;`; res_src=1, res_pass=0, res_timeout=1; next S1 statement "int q;" gives res_pass=1.
- reset asserted mid "int xy" → no res_valid; chk_reset high; after release, "int z;" gives res_pass=1.
- With STMT_CHECK_STATS_EN, 3 passes, 2 fails, 1 timeout → pass_cnt=3, fail_cnt=3, to_cnt=1.
